// File: rtl/mdc_out_reorder_if.sv
// ============================================================================
//  Module   : mdc_out_reorder_if
//  Brief    : Pair-input / serial-output bus of the MDC FFT output reorder stage
//             (do_sof/do_eof present when MDC_REORDER_FRAME_MARK_EN is defined).
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mdc_out_reorder_if #(
    parameter int DW = 13
);
    logic          di_en;
    logic          di_rdy;
    logic [DW-1:0] di_re_a;
    logic [DW-1:0] di_im_a;
    logic [DW-1:0] di_re_b;
    logic [DW-1:0] di_im_b;
    logic          do_en;
    logic [DW-1:0] do_re;
    logic [DW-1:0] do_im;
`ifdef MDC_REORDER_FRAME_MARK_EN
    logic          do_sof;
    logic          do_eof;

    modport master (
        output di_en, di_re_a, di_im_a, di_re_b, di_im_b,
        input  di_rdy, do_en, do_re, do_im, do_sof, do_eof
    );
    modport slave (
        input  di_en, di_re_a, di_im_a, di_re_b, di_im_b,
        output di_rdy, do_en, do_re, do_im, do_sof, do_eof
    );
`else
    modport master (
        output di_en, di_re_a, di_im_a, di_re_b, di_im_b,
        input  di_rdy, do_en, do_re, do_im
    );
    modport slave (
        input  di_en, di_re_a, di_im_a, di_re_b, di_im_b,
        output di_rdy, do_en, do_re, do_im
    );
`endif
endinterface

`default_nettype wire

// File: rtl/mdc_out_reorder.sv
// ============================================================================
//  Module   : mdc_out_reorder
//  Brief    : 32-point MDC FFT output stage: ping-pong bit-reversal buffer to
//             natural-order serial stream. Optional MDC_REORDER_FRAME_MARK_EN
//             adds do_sof/do_eof frame markers.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mdc_out_reorder #(
    parameter int DW  = 13,
    parameter int NPT = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mdc_out_reorder_if.slave   bus
);
    localparam int AW = $clog2(NPT);
    localparam int HW = AW - 1;
    localparam logic [AW-1:0] c_last_rd = AW'(NPT - 1);
    localparam logic [HW-1:0] c_last_wr = HW'(NPT / 2 - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_full, w_full_nxt;
    logic            r_wr_bank, w_wr_bank_nxt;
    logic            r_rd_bank, w_rd_bank_nxt;
    logic [HW-1:0]   r_wr_cnt, w_wr_cnt_nxt;
    logic [AW-1:0]   r_rd_cnt, w_rd_cnt_nxt;
    logic            r_rdy, w_rdy_nxt;
    logic            r_do_en, w_do_en_nxt;
    logic [DW-1:0]   r_do_re, w_do_re_nxt;
    logic [DW-1:0]   r_do_im, w_do_im_nxt;
    logic            r_sof, w_sof_nxt;
    logic            r_eof, w_eof_nxt;

    // Lane A always lands in the lower half (bitrev of an even index), lane B
    // in the upper half, so each half is a single-write-port RAM.
    logic [2*DW-1:0] r_mem_lo [0:NPT-1];
    logic [2*DW-1:0] r_mem_hi [0:NPT-1];

    logic            w_wr_fire, w_wr_done, w_rd_done;
    logic [HW-1:0]   w_wr_addr;
    logic [AW-1:0]   w_rd_idx;
    logic [2*DW-1:0] w_rd_word;

    assign w_wr_fire = bus.di_en & r_rdy;
    assign w_wr_done = w_wr_fire && (r_wr_cnt == c_last_wr);
    assign w_rd_done = (r_state == ST_RUN) && (r_rd_cnt == c_last_rd);
    assign w_rd_idx  = {r_rd_bank, r_rd_cnt[HW-1:0]};
    assign w_rd_word = r_rd_cnt[AW-1] ? r_mem_hi[w_rd_idx] : r_mem_lo[w_rd_idx];

    always_comb begin
        w_wr_addr = '0;
        for (int i = 0; i < HW; i++) begin
            w_wr_addr[i] = r_wr_cnt[HW-1-i];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem_lo[{r_wr_bank, w_wr_addr}] <= {bus.di_re_a, bus.di_im_a};
            r_mem_hi[{r_wr_bank, w_wr_addr}] <= {bus.di_re_b, bus.di_im_b};
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_full_nxt    = r_full;
        w_wr_bank_nxt = r_wr_bank;
        w_rd_bank_nxt = r_rd_bank;
        w_wr_cnt_nxt  = r_wr_cnt;
        w_rd_cnt_nxt  = r_rd_cnt;
        w_do_en_nxt   = 1'b0;
        w_do_re_nxt   = '0;
        w_do_im_nxt   = '0;
        w_sof_nxt     = 1'b0;
        w_eof_nxt     = 1'b0;

        if (w_wr_fire) begin
            w_wr_cnt_nxt = r_wr_cnt + 1'b1;
        end
        if (w_wr_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
            w_wr_bank_nxt         = ~r_wr_bank;
        end

        case (r_state)
            ST_IDLE: begin
                w_rd_cnt_nxt = '0;
                if (r_full[r_rd_bank]) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_do_en_nxt  = 1'b1;
                w_do_re_nxt  = w_rd_word[2*DW-1:DW];
                w_do_im_nxt  = w_rd_word[DW-1:0];
                w_sof_nxt    = (r_rd_cnt == '0);
                w_eof_nxt    = w_rd_done;
                w_rd_cnt_nxt = r_rd_cnt + 1'b1;
                if (w_rd_done) begin
                    w_full_nxt[r_rd_bank] = 1'b0;
                    w_rd_bank_nxt         = ~r_rd_bank;
                    w_rd_cnt_nxt          = '0;
                    // A frame completing this very cycle counts as ready.
                    if (!w_full_nxt[~r_rd_bank]) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
        endcase

        w_rdy_nxt = ~w_full_nxt[w_wr_bank_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state   <= ST_IDLE;
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_rdy     <= 1'b1;
            r_do_en   <= 1'b0;
            r_do_re   <= '0;
            r_do_im   <= '0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_full    <= w_full_nxt;
            r_wr_bank <= w_wr_bank_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            r_wr_cnt  <= w_wr_cnt_nxt;
            r_rd_cnt  <= w_rd_cnt_nxt;
            r_rdy     <= w_rdy_nxt;
            r_do_en   <= w_do_en_nxt;
            r_do_re   <= w_do_re_nxt;
            r_do_im   <= w_do_im_nxt;
            r_sof     <= w_sof_nxt;
            r_eof     <= w_eof_nxt;
        end
    end

    assign bus.di_rdy = r_rdy;
    assign bus.do_en  = r_do_en;
    assign bus.do_re  = r_do_re;
    assign bus.do_im  = r_do_im;

`ifdef MDC_REORDER_FRAME_MARK_EN
    assign bus.do_sof = r_sof;
    assign bus.do_eof = r_eof;
`else
    logic w_marks_unused;
    assign w_marks_unused = r_sof ^ r_eof;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mdc_out_reorder.sv
// ============================================================================
//  Module   : tb_mdc_out_reorder
//  Brief    : Self-checking bench for mdc_out_reorder (scoreboard + vector table).
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mdc_out_reorder;
    localparam int DW = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mdc_out_reorder_if #(.DW(DW)) bus ();
    mdc_out_reorder #(.DW(DW), .NPT(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } samp_t;

    typedef struct {
        int pat;
        int gap;
        bit bnd;
        int exp_lat;
        int exp_len;
    } vec_t;

    samp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    edge_cnt = 0;
    int    last_acc_edge = 0;
    int    out_idx = 0;
    int    run_len = 0;
    int    last_run = 0;
    bit    rdy_probe = 1'b0;
    bit    probe_done = 1'b0;
    logic  prev_rdy = 1'b1;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int br5(input int x);
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if (x[b]) r = r | (1 << (4 - b));
        end
        return r;
    endfunction

    // Output monitor / scoreboard
    always @(posedge clk) begin
        samp_t s;
        #1;
        if (bus.do_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got re=%0h im=%0h expected no output", bus.do_re, bus.do_im);
            end else begin
                s = exp_q.pop_front();
                chk("sample_re", 32'(bus.do_re), 32'(s.re));
                chk("sample_im", 32'(bus.do_im), 32'(s.im));
            end
`ifdef MDC_REORDER_FRAME_MARK_EN
            chk("sof", 32'(bus.do_sof), 32'(out_idx % 32 == 0));
            chk("eof", 32'(bus.do_eof), 32'(out_idx % 32 == 31));
`endif
            if (rdy_probe && !probe_done && (out_idx % 32 == 31)) begin
                chk("rdy_low_before_free", 32'(prev_rdy), 32'd0);
                chk("rdy_rise_after_free", 32'(bus.di_rdy), 32'd1);
                probe_done = 1'b1;
            end
            out_idx++;
            run_len++;
        end else begin
            chk("idle_zero", 32'({bus.do_re, bus.do_im}), 32'd0);
`ifdef MDC_REORDER_FRAME_MARK_EN
            chk("idle_marks", 32'({bus.do_sof, bus.do_eof}), 32'd0);
`endif
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
        prev_rdy = bus.di_rdy;
    end

    task automatic send_frame(input int pat, input int gap, input bit bnd, input int npairs);
        samp_t         fb[32];
        logic [DW-1:0] ra, ia, rb, ib;
        bit            tog = 1'b1;
        for (int c = 0; c < npairs; c++) begin
            bit accepted = 1'b0;
            int tries = 0;
            if (pat == 0) begin
                ra = DW'(br5(2 * c));
                rb = DW'(br5(2 * c + 1));
                ia = -ra;
                ib = -rb;
            end else begin
                ra = DW'($urandom_range(0, 8191));
                ia = DW'($urandom_range(0, 8191));
                rb = DW'($urandom_range(0, 8191));
                ib = DW'($urandom_range(0, 8191));
            end
            if (bnd && c == 15) begin
                rb = 13'h0FFF;
                ib = 13'h1000;
            end
            while (!accepted && tries < 400) begin
                logic en, rdy;
                case (gap)
                    0:       en = 1'b1;
                    1:       begin en = tog; tog = !tog; end
                    default: en = 1'($urandom_range(0, 1));
                endcase
                bus.di_en = en;
                if (en) begin
                    bus.di_re_a = ra; bus.di_im_a = ia;
                    bus.di_re_b = rb; bus.di_im_b = ib;
                end else begin
                    bus.di_re_a = DW'($urandom); bus.di_im_a = DW'($urandom);
                    bus.di_re_b = DW'($urandom); bus.di_im_b = DW'($urandom);
                end
                rdy = bus.di_rdy;
                @(posedge clk);
                #1;
                if (en && rdy) begin
                    accepted = 1'b1;
                    last_acc_edge = edge_cnt;
                end
                tries++;
            end
            if (!accepted) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: pair %0d not accepted, expected acceptance within 400 cycles", c);
            end
            fb[br5(2 * c)]     = {ra, ia};
            fb[br5(2 * c + 1)] = {rb, ib};
        end
        bus.di_en = 1'b0;
        if (npairs == 16) begin
            for (int n = 0; n < 32; n++) exp_q.push_back(fb[n]);
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || bus.do_en === 1'b1) && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic measure_frame(input int exp_lat, input int exp_len);
        int w = 0;
        int n = 0;
        while (bus.do_en !== 1'b1 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("latency", 32'(edge_cnt - last_acc_edge), 32'(exp_lat));
        while (bus.do_en === 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("frame_len", 32'(n), 32'(exp_len));
    endtask

    initial begin
        vec_t tbl[4];
        int   cnt;
        tbl[0] = '{0, 0, 1'b0, 2, 32};
        tbl[1] = '{0, 1, 1'b0, 2, 32};
        tbl[2] = '{1, 2, 1'b1, 2, 32};
        tbl[3] = '{1, 0, 1'b1, 2, 32};

        bus.di_en = 1'b0;
        bus.di_re_a = '0; bus.di_im_a = '0;
        bus.di_re_b = '0; bus.di_im_b = '0;

        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_do_en", 32'(bus.do_en), 32'd0);
        chk("reset_do_re", 32'(bus.do_re), 32'd0);
        chk("reset_do_im", 32'(bus.do_im), 32'd0);
        chk("reset_di_rdy", 32'(bus.di_rdy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].pat, tbl[i].gap, tbl[i].bnd, 16);
            measure_frame(tbl[i].exp_lat, tbl[i].exp_len);
            drain();
        end

        // Three frames back-to-back: stall, bubble-free output, ordered data
        probe_done = 1'b0;
        rdy_probe  = 1'b1;
        send_frame(1, 0, 1'b0, 16);
        send_frame(1, 0, 1'b1, 16);
        chk("rdy_fall_after_second_bank", 32'(bus.di_rdy), 32'd0);
        send_frame(0, 0, 1'b0, 16);
        drain();
        rdy_probe = 1'b0;
        chk("rdy_probe_seen", 32'(probe_done), 32'd1);
        chk("contiguous_96", 32'(last_run), 32'd96);

        // Reset in the middle of a frame discards it
        send_frame(1, 0, 1'b0, 9);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        chk("midreset_do_en", 32'(bus.do_en), 32'd0);
        chk("midreset_di_rdy", 32'(bus.di_rdy), 32'd1);
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.do_en === 1'b1) cnt++;
        end
        chk("no_output_after_reset", 32'(cnt), 32'd0);
        send_frame(0, 1, 1'b1, 16);
        measure_frame(2, 32);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded 1 ms, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/mdc_out_reorder.md
Name: mdc_out_reorder

Overview:
- Output stage of the 32-point radix-2 MDC FFT.
- Accepts the two parallel lanes from the last butterfly stage, which arrive in bit-reversed pair order.
- Buffers each frame in a ping-pong RAM and emits one serial, natural-order complex sample per cycle (X[0]..X[31]).
- Applies back-pressure to the pipeline when both banks are occupied.

Parameters:
- DW, 13: width of each real/imag component, two's complement.
- NPT, 32: points per frame; only 32 is supported (log2 = 5).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous, active-high reset
- di_en  input  1  input pair valid
- di_rdy  output  1  block can accept a pair this cycle
- di_re_a  input  DW  lane A real
- di_im_a  input  DW  lane A imag
- di_re_b  input  DW  lane B real
- di_im_b  input  DW  lane B imag
- do_en  output  1  output sample valid
- do_re  output  DW  output real
- do_im  output  DW  output imag

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: do_en=0, do_re=0, do_im=0, di_rdy=1.
  - State: both bank-full flags cleared, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0.
  - A reset mid-frame discards partial and buffered frames; no further do_en until a new full frame is written.
- Input transfer occurs on a rising edge with di_en=1 and di_rdy=1. di_en while di_rdy=0 is ignored; the data is dropped and wr_cnt holds.
- Write mapping:
  - wr_cnt c runs 0..15 within a frame.
  - Lane A is written to address bitrev5(2c); lane B to address bitrev5(2c)+16 (equal to bitrev5(2c+1)).
  - Example: c=0 -> A@0, B@16; c=1 -> A@8, B@24; c=15 -> A@15, B@31.
- Frame completion: on the transfer with wr_cnt=15, set full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0.
- di_rdy = !full[wr_bank], registered. It falls the cycle after the second bank fills.
- Read state machine:
  - IDLE -> RUN when full[rd_bank]=1.
  - In RUN, rd_cnt advances 0..31, one sample per cycle, reading address rd_cnt.
  - At rd_cnt=31: clear full[rd_bank], toggle rd_bank. If the other bank is already full, stay in RUN with rd_cnt=0 (no gap between frames); otherwise go to IDLE.
- Latency: if the last pair of a frame is accepted on edge k while the reader is IDLE, X[0] is presented with do_en=1 after edge k+2, followed by 31 further consecutive cycles.
- Output registers: do_en, do_re and do_im are registered. When do_en=0, do_re and do_im hold 0.
- Simultaneous events:
  - Reader freeing a bank in the same cycle the writer is stalled on that bank: di_rdy rises on the next edge (one-cycle bubble, no data loss).
  - Writer filling a bank in the same cycle the reader finishes the other bank: the reader continues seamlessly.
- Throughput: sustained input is at most 16 pairs per 32 cycles. A faster source is throttled by di_rdy.
- Data passes unmodified: no scaling, no sign extension, full DW bits.

Optional Feature:
- Macro: MDC_REORDER_FRAME_MARK_EN.
- When defined, two output ports are added:
  - do_sof (1 bit): high with X[0].
  - do_eof (1 bit): high with X[31].
  - Both are registered, reset to 0, and aligned with do_en.
- When undefined, these ports and their logic are absent. Core behaviour is identical either way.

Test Plan:
- Reset, then 16 consecutive pairs with lane A re = bitrev5(2c), lane B re = bitrev5(2c)+16, im = -re -> do_re = 0,1,...,31 and do_im = 0,-1,...,-31 in order; X[0] appears 2 cycles after the last pair; do_en high for exactly 32 cycles.
- Same frame with di_en toggled every other cycle -> identical 32-sample output starting 2 cycles after the 16th accepted pair.
- Three frames sent back-to-back with di_en held high -> di_rdy falls after frame 2 fills and rises one cycle after frame 1 readout ends. Output: 96 contiguous do_en cycles, frames in order, with no dropped or duplicated samples.
- Assert rst_n at pair 9 of frame 1 -> do_en stays 0. A new full frame sent after reset is output correctly with frame-1 data absent.
- Boundary values (re=4095, im=-4096 in lane B at c=15) -> X[31] = 4095/-4096 bit-exact.
- With MDC_REORDER_FRAME_MARK_EN defined, two back-to-back frames -> do_sof pulses exactly at samples 0 and 32, and do_eof exactly at samples 31 and 63.
